// File: rtl/opn_inject_scheduler.sv
// Local injection scheduler: arbitrates tile producers onto one operand-network router
// port, issues each flit as a one-cycle req and re-issues it until the router acks.
module opn_inject_scheduler #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned FLIT_W    = 64,
   parameter int unsigned AGE_LIMIT = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*FLIT_W-1:0]   src_flit,
   input  logic [NUM_SRC-1:0]          src_high_pri,
   output logic [NUM_SRC-1:0]          src_ready,
   output logic                        inj_req_out,
   output logic [FLIT_W-1:0]           inj_flit_out,
   input  logic                        inj_ack_in,
   input  logic                        flush,
   output logic                        busy,
   output logic [15:0]                 retry_count,
   output logic [31:0]                 flit_count
);
   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned AGE_W = 8;
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [FLIT_W-1:0]  hold_q, hold_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [AGE_W-1:0]   age_q [NUM_SRC];
   logic [AGE_W-1:0]   age_d [NUM_SRC];
   logic [15:0]        retry_q, retry_d;
   logic [31:0]        fcnt_q, fcnt_d;
   logic               grant;
   logic               win_found;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   idx_n;
   logic [NUM_SRC-1:0] cand;
   int unsigned        idx;

   // Winner: lowest-index aged source, else round-robin from rr_ptr within the active class.
   always_comb begin
      win_found = 1'b0;
      win       = '0;
      idx       = 0;
      idx_n     = '0;
      cand      = (|(src_valid & src_high_pri)) ? (src_valid & src_high_pri) : src_valid;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!win_found && src_valid[i] && (age_q[i] == AGE_MAX)) begin
            win_found = 1'b1;
            win       = IDX_W'(i);
         end
      end
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         idx_n = IDX_W'(idx);
         if (!win_found && cand[idx_n]) begin
            win_found = 1'b1;
            win       = idx_n;
         end
      end
   end

   // Next-state, counters and hold register; flush overrides everything outside IDLE.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      rr_ptr_d = rr_ptr_q;
      retry_d  = retry_q;
      fcnt_d   = fcnt_q;
      grant    = 1'b0;
      unique case (state_q)
         IDLE:  grant = |src_valid;
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (inj_ack_in) begin
               fcnt_d = fcnt_q + 32'd1;
               if (|src_valid) grant = 1'b1;
               else            state_d = IDLE;
            end else begin
               if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
               state_d = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush && (state_q != IDLE)) begin
         state_d = IDLE;
         grant   = 1'b0;
         fcnt_d  = fcnt_q;
         retry_d = retry_q;
      end
      if (grant) begin
         state_d  = ISSUE;
         hold_d   = src_flit[32'(win)*FLIT_W +: FLIT_W];
         rr_ptr_d = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
      end else if (state_d == IDLE) begin
         hold_d = '0;
      end
   end

   // Per-source wait age, saturating; cleared when idle-valid drops or on grant.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!src_valid[i] || (grant && (win == IDX_W'(i)))) age_d[i] = '0;
         else if (age_q[i] == AGE_MAX)                       age_d[i] = age_q[i];
         else                                                age_d[i] = age_q[i] + AGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         rr_ptr_q <= '0;
         retry_q  <= '0;
         fcnt_q   <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) age_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         rr_ptr_q <= rr_ptr_d;
         retry_q  <= retry_d;
         fcnt_q   <= fcnt_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) age_q[i] <= age_d[i];
      end
   end

   assign src_ready    = grant ? (NUM_SRC'(1) << win) : '0;
   assign inj_req_out  = (state_q == ISSUE) && !flush;
   assign inj_flit_out = hold_q;
   assign busy         = (state_q != IDLE);
   assign retry_count  = retry_q;
   assign flit_count   = fcnt_q;

endmodule

// File: doc/opn_inject_scheduler.md
Name: opn_inject_scheduler

Overview:
- Shares one operand-network router local injection port among NUM_SRC local producers in an execution tile (ALU result, register-read forward, load return, etc.).
- Arbitrates producers with two priority classes, round-robin within a class, and age-based anti-starvation.
- Captures the winning flit and drives it into the router local port using a single-cycle req pulse.
- Waits for the router's registered ack and retries the flit if no ack arrives.

Parameters:
- NUM_SRC, 4: number of local producers (2..8).
- FLIT_W, 64: flit width in bits; matches generic_flit_t.
- AGE_LIMIT, 15: wait cycles after which a pending source overrides class priority (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  producer i holds a flit
- src_flit  in  NUM_SRC*FLIT_W  producer flits; slice i = [i*FLIT_W +: FLIT_W]
- src_high_pri  in  NUM_SRC  producer i is high-priority class
- src_ready  out  NUM_SRC  one-hot pulse; flit i captured this cycle
- inj_req_out  out  1  to router local req_in
- inj_flit_out  out  FLIT_W  to router local flit_in
- inj_ack_in  in  1  from router local ack_out (registered by router)
- flush  in  1  synchronous abort of the held flit
- busy  out  1  a flit is held (state != IDLE)
- retry_count  out  16  saturating count of re-issues
- flit_count  out  32  wrapping count of acked flits

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, inj_req_out=0, inj_flit_out=0, src_ready=0, busy=0, counters=0, rr_ptr=0, all ages=0.
- Reset mid-operation drops the held flit immediately.
- Source protocol: a producer holds src_valid and src_flit stable until src_ready[i].
- src_ready is combinational, asserted only in a grant cycle.
- Grant selection, when a grant is permitted:
  - Any source with age==AGE_LIMIT wins; lowest index among aged sources.
  - Otherwise, if any valid source is high-pri, round-robin among high-pri sources from rr_ptr.
  - Otherwise, round-robin among all valid sources from rr_ptr.
- On grant: hold<=src_flit[w], src_ready[w]=1, rr_ptr<=(w+1)%NUM_SRC, state<=ISSUE.
- Age per source:
  - Cleared to 0 when the source is not valid or is granted.
  - Otherwise +1 per cycle, saturating at AGE_LIMIT.
- State IDLE: grant is permitted; otherwise stay in IDLE.
- State ISSUE:
  - inj_req_out=1 for exactly this cycle; inj_flit_out=hold.
  - Next state is WAIT.
  - inj_flit_out keeps the hold value in every non-IDLE state.
- State WAIT:
  - inj_req_out=0. The router's ack for an ISSUE cycle is observed in the following WAIT cycle.
  - Ack received: flit_count+1. If any source is valid, grant in this same cycle and go to ISSUE (2 cycles/flit sustained); otherwise go to IDLE.
  - No ack (router buffer full): retry_count+1 (saturate at 16'hFFFF) and go to ISSUE with the same flit. There is no retry limit.
- req is never held high across consecutive cycles, so the router cannot enqueue a flit twice.
- inj_ack_in in IDLE or ISSUE is ignored.
- flush (highest precedence):
  - Next state is IDLE; inj_req_out=0 that cycle; no grant that cycle; hold is discarded.
  - An ack in the flush cycle is ignored.
  - flush in IDLE has no effect.
- busy = (state != IDLE).

Test Plan:
- Src1 only, valid, flit=0xA5; ack returned in the WAIT cycle -> src_ready=0b0010 at cycle 0; req=1 at cycle 1 with flit 0xA5; flit_count=1; IDLE at cycle 3.
- Src0..3 all valid, low-pri, ack always returned -> grants 0,1,2,3,0 on successive ISSUEs, 2 cycles apart.
- Src0 low-pri and src2 high-pri both valid -> src2 granted first; with src2 continuously high-pri and AGE_LIMIT=15, src0 is granted after age reaches 15.
- No ack for 3 WAIT cycles, then ack -> 4 req pulses carrying the same flit, never on adjacent cycles; retry_count=3; flit_count=1.
- flush asserted in WAIT -> IDLE next cycle; req stays 0; flit_count unchanged; a late ack is ignored.
- rst_n dropped while in ISSUE -> inj_req_out=0 and busy=0 immediately; all counters 0.
